// File: rtl/hvsync_generator.sv
// hvsync_generator: free-running video timing generator (beam counters, registered syncs, display_on)
//   clk        pixel clock, all state on rising edge
//   reset      asynchronous active-low reset
//   hsync      registered horizontal sync pulse
//   vsync      registered vertical sync pulse
//   display_on high while the beam is in the visible area (combinational)
//   hpos/vpos  9-bit beam counters, 0..H_MAX / 0..V_MAX
// Build option HVSYNC_NEG_POLARITY_EN: active-low sync pulses (idle/reset level 1).
module hvsync_generator #(
    parameter int H_DISPLAY = 256,
    parameter int H_BACK    = 23,
    parameter int H_FRONT   = 7,
    parameter int H_SYNC    = 23,
    parameter int V_DISPLAY = 240,
    parameter int V_TOP     = 5,
    parameter int V_BOTTOM  = 14,
    parameter int V_SYNC    = 3
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [8:0] hpos,
    output logic [8:0] vpos
);
    localparam logic [8:0] H_DISP       = 9'(H_DISPLAY);
    localparam logic [8:0] H_SYNC_START = 9'(H_DISPLAY + H_FRONT);
    localparam logic [8:0] H_SYNC_END   = 9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [8:0] H_MAX        = 9'(H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1);
    localparam logic [8:0] V_DISP       = 9'(V_DISPLAY);
    localparam logic [8:0] V_SYNC_START = 9'(V_DISPLAY + V_BOTTOM);
    localparam logic [8:0] V_SYNC_END   = 9'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    localparam logic [8:0] V_MAX        = 9'(V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1);
`ifdef HVSYNC_NEG_POLARITY_EN
    localparam logic ACT = 1'b0;
`else
    localparam logic ACT = 1'b1;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hpos  <= '0;
            vpos  <= '0;
            hsync <= ~ACT;
            vsync <= ~ACT;
        end else begin
            hpos <= (hpos == H_MAX) ? 9'd0 : hpos + 9'd1;
            if (hpos == H_MAX)
                vpos <= (vpos == V_MAX) ? 9'd0 : vpos + 9'd1;
            // syncs are sampled on the pre-increment counters, so they lag by one clk
            hsync <= (hpos >= H_SYNC_START && hpos <= H_SYNC_END) ? ACT : ~ACT;
            vsync <= (vpos >= V_SYNC_START && vpos <= V_SYNC_END) ? ACT : ~ACT;
        end
    end
    assign display_on = (hpos < H_DISP) && (vpos < V_DISP);
endmodule

// File: tb/tb_hvsync_generator.sv
// tb_hvsync_generator: checks hvsync_generator against an arithmetic beam-position model
module tb_hvsync_generator;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hsync, vsync, display_on;
    logic [8:0] hpos, vpos;
    int         tests = 0;
    int         fails = 0;
    int         n = 0;
`ifdef HVSYNC_NEG_POLARITY_EN
    localparam int ACT = 0;
`else
    localparam int ACT = 1;
`endif
    localparam int IDLE = 1 - ACT;

    hvsync_generator dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .hpos(hpos), .vpos(vpos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at n=%0d: got %0d expected %0d", nm, n, act, exp);
        end
    endtask

    // n = clock edges seen since reset was last released
    always @(posedge clk or negedge reset)
        if (!reset) n <= 0;
        else n <= n + 1;

    always @(negedge clk) begin : cmp
        int h, v, ph, pv, eh, ev;
        h  = n % 309;
        v  = (n / 309) % 262;
        ph = (n - 1) % 309;
        pv = ((n - 1) / 309) % 262;
        eh = (n > 0 && ph >= 263 && ph <= 285) ? ACT : IDLE;
        ev = (n > 0 && pv >= 254 && pv <= 256) ? ACT : IDLE;
        chk("hpos", hpos, h);
        chk("vpos", vpos, v);
        chk("hsync", hsync, eh);
        chk("vsync", vsync, ev);
        chk("display_on", display_on, (h < 256 && v < 240) ? 1 : 0);
        case (n)
            255:   chk("disp_255_0", display_on, 1);
            256:   chk("disp_256_0", display_on, 0);
            263:   chk("hsync_before_rise", hsync, IDLE);
            264:   chk("hsync_rise", hsync, ACT);
            286:   chk("hsync_last", hsync, ACT);
            287:   chk("hsync_fall", hsync, IDLE);
            308:   chk("hpos_max", hpos, 308);
            309:   begin chk("hwrap_hpos", hpos, 0); chk("hwrap_vpos", vpos, 1); end
            74106: chk("disp_255_239", display_on, 1);
            74160: chk("disp_0_240", display_on, 0);
            78486: begin chk("vsync_pre_vpos", vpos, 254); chk("vsync_pre", vsync, IDLE); end
            78487: chk("vsync_rise", vsync, ACT);
            79413: begin chk("vsync_last_vpos", vpos, 257); chk("vsync_last", vsync, ACT); end
            79414: chk("vsync_fall", vsync, IDLE);
            80957: begin chk("end_hpos", hpos, 308); chk("end_vpos", vpos, 261); end
            80958: begin chk("fwrap_hpos", hpos, 0); chk("fwrap_vpos", vpos, 0); end
            default: ;
        endcase
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (100) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("rst_hpos", hpos, 0);
        chk("rst_vpos", vpos, 0);
        chk("rst_hsync", hsync, IDLE);
        chk("rst_vsync", vsync, IDLE);
        repeat (5) @(posedge clk);
        #1;
        chk("rst_hold_hpos", hpos, 0);
        #1 reset = 1'b1;
        repeat (80958 + 400) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
